// File: rtl/sram_bus_ctrl.sv
// Single-word bus to dual-bank asynchronous SRAM controller.
// Every strobe, address and bus enable comes straight from a flop.
module sram_bus_ctrl (
    input  logic        clk_50M,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [20:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    inout  wire  [31:0] base_ram_data,
    output logic [19:0] base_ram_addr,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,
    inout  wire  [31:0] ext_ram_data,
    output logic [19:0] ext_ram_addr,
    output logic [3:0]  ext_ram_be_n,
    output logic        ext_ram_ce_n,
    output logic        ext_ram_oe_n,
    output logic        ext_ram_we_n
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_e;

    state_e      state_q;
    logic        sel_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        ack_q;
    logic        busy_q;
    logic [1:0]  ce_n_q;
    logic [1:0]  oe_n_q;
    logic [1:0]  we_n_q;
    logic [1:0]  drive_q;
    logic [3:0]  be_n_q [2];
    logic [19:0] addr_q [2];

    // Index 0 is BaseRAM, index 1 is ExtRAM, matching addr[20].
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            ce_n_q    <= 2'b11;
            oe_n_q    <= 2'b11;
            we_n_q    <= 2'b11;
            drive_q   <= 2'b00;
            be_n_q[0] <= '0;
            be_n_q[1] <= '0;
            addr_q[0] <= '0;
            addr_q[1] <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (req) begin
                        sel_q                <= addr[20];
                        wdata_q              <= wdata;
                        busy_q               <= 1'b1;
                        addr_q[addr[20]]     <= addr[19:0];
                        ce_n_q[addr[20]]     <= 1'b0;
                        if (we) begin
                            be_n_q[addr[20]]  <= ~be;
                            drive_q[addr[20]] <= 1'b1;
                            state_q           <= WR_SETUP;
                        end else begin
                            be_n_q[addr[20]]  <= 4'b0000;
                            oe_n_q[addr[20]]  <= 1'b0;
                            state_q           <= RD;
                        end
                    end
                end
                RD: begin
                    rdata_q <= sel_q ? ext_ram_data : base_ram_data;
                    ce_n_q  <= 2'b11;
                    oe_n_q  <= 2'b11;
                    ack_q   <= 1'b1;
                    state_q <= DONE;
                end
                WR_SETUP: begin
                    we_n_q[sel_q] <= 1'b0;
                    state_q       <= WR_PULSE;
                end
                WR_PULSE: begin
                    we_n_q[sel_q] <= 1'b1;
                    state_q       <= WR_HOLD;
                end
                WR_HOLD: begin
                    ce_n_q  <= 2'b11;
                    drive_q <= 2'b00;
                    ack_q   <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ce_n_q  <= 2'b11;
                    oe_n_q  <= 2'b11;
                    we_n_q  <= 2'b11;
                    drive_q <= 2'b00;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // BaseRAM data[7:0] is shared with the CPLD UART: drive only while writing.
    assign base_ram_data = drive_q[0] ? wdata_q : 32'bz;
    assign ext_ram_data  = drive_q[1] ? wdata_q : 32'bz;

    assign base_ram_addr = addr_q[0];
    assign base_ram_be_n = be_n_q[0];
    assign base_ram_ce_n = ce_n_q[0];
    assign base_ram_oe_n = oe_n_q[0];
    assign base_ram_we_n = we_n_q[0];

    assign ext_ram_addr  = addr_q[1];
    assign ext_ram_be_n  = be_n_q[1];
    assign ext_ram_ce_n  = ce_n_q[1];
    assign ext_ram_oe_n  = oe_n_q[1];
    assign ext_ram_we_n  = we_n_q[1];

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Bench for sram_bus_ctrl: two small async SRAM models plus a
// read-data scoreboard fed by the stimulus and drained on ack.
module tb_sram_bus_ctrl;

    logic        clk_50M = 1'b0;
    logic        reset_n = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [20:0] addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;
    wire  [31:0] base_ram_data;
    logic [19:0] base_ram_addr;
    logic [3:0]  base_ram_be_n;
    logic        base_ram_ce_n;
    logic        base_ram_oe_n;
    logic        base_ram_we_n;
    wire  [31:0] ext_ram_data;
    logic [19:0] ext_ram_addr;
    logic [3:0]  ext_ram_be_n;
    logic        ext_ram_ce_n;
    logic        ext_ram_oe_n;
    logic        ext_ram_we_n;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] base_mem [16];
    logic [31:0] ext_mem  [16];

    always #10 clk_50M = ~clk_50M;

    sram_bus_ctrl dut (
        .clk_50M(clk_50M), .reset_n(reset_n),
        .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .rdata(rdata), .ack(ack), .busy(busy),
        .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr),
        .base_ram_be_n(base_ram_be_n), .base_ram_ce_n(base_ram_ce_n),
        .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
        .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr),
        .ext_ram_be_n(ext_ram_be_n), .ext_ram_ce_n(ext_ram_ce_n),
        .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n)
    );

    // Async SRAM models: drive on ce&oe, latch enabled bytes on rising we_n.
    assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n && base_ram_we_n)
                           ? base_mem[base_ram_addr[3:0]] : 32'bz;
    assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n && ext_ram_we_n)
                           ? ext_mem[ext_ram_addr[3:0]] : 32'bz;

    always @(posedge base_ram_we_n)
        if (base_ram_ce_n === 1'b0)
            for (int i = 0; i < 4; i++)
                if (!base_ram_be_n[i])
                    base_mem[base_ram_addr[3:0]][8*i +: 8] = base_ram_data[8*i +: 8];

    always @(posedge ext_ram_we_n)
        if (ext_ram_ce_n === 1'b0)
            for (int i = 0; i < 4; i++)
                if (!ext_ram_be_n[i])
                    ext_mem[ext_ram_addr[3:0]][8*i +: 8] = ext_ram_data[8*i +: 8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every ack consumes one expectation.
    always @(negedge clk_50M) begin
        if (reset_n && ack) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack with empty queue");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.rd) chk("rdata", {32'd0, rdata}, {32'd0, e.data});
            end
        end
    end

    task automatic access(input logic w, input logic [20:0] a,
                          input logic [3:0] b, input logic [31:0] d,
                          input logic [31:0] expd,
                          output int lat, output int ce_cyc,
                          output int we_cyc, output int oth_cyc,
                          output logic [3:0] be_at_we);
        logic s;
        s = a[20];
        ce_cyc = 0; we_cyc = 0; oth_cyc = 0; be_at_we = 4'hx;
        sb_q.push_back('{rd: !w, data: expd});
        @(negedge clk_50M);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(negedge clk_50M);
        req = 1'b0; we = 1'b0; addr = '1; be = '1; wdata = '1;
        lat = 1;
        forever begin
            if (!(s ? ext_ram_ce_n : base_ram_ce_n)) ce_cyc++;
            if (!(s ? ext_ram_we_n : base_ram_we_n)) begin
                we_cyc++;
                be_at_we = s ? ext_ram_be_n : base_ram_be_n;
            end
            if (s ? !(base_ram_ce_n && base_ram_oe_n && base_ram_we_n)
                  : !(ext_ram_ce_n && ext_ram_oe_n && ext_ram_we_n))
                oth_cyc++;
            if (ack || lat >= 10) break;
            @(negedge clk_50M);
            lat++;
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_strobes"},
            {58'd0, base_ram_ce_n, base_ram_oe_n, base_ram_we_n,
             ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}, 64'h3f);
        chk({tag, "_drive"}, {62'd0, dut.drive_q}, 64'd0);
        chk({tag, "_rdata_ack_busy"}, {30'd0, rdata, ack, busy}, 64'd0);
        chk({tag, "_be_n"}, {56'd0, base_ram_be_n, ext_ram_be_n}, 64'd0);
        chk({tag, "_addr"}, {24'd0, base_ram_addr, ext_ram_addr}, 64'd0);
    endtask

    initial begin
        int lat, cc, wc, oc;
        logic [3:0] bw;
        int acks[$];
        for (int i = 0; i < 16; i++) begin
            base_mem[i] = 32'h0;
            ext_mem[i]  = 32'h0;
        end
        base_mem[0] = 32'h3C1F8040;
        base_mem[1] = 32'h01234567;
        base_mem[3] = 32'h55AA55AA;
        base_mem[7] = 32'hDEADBEEF;
        ext_mem[5]  = 32'h11223344;

        #5 reset_n = 1'b0;
        #1 reset_checks("por");
        repeat (2) @(negedge clk_50M);
        reset_n = 1'b1;

        access(1'b0, 21'h000000, 4'hF, 32'h0, 32'h3C1F8040,
               lat, cc, wc, oc, bw);
        chk("base_rd_lat", lat, 2);
        chk("base_rd_ce_cycles", cc, 1);
        chk("base_rd_ext_quiet", oc, 0);

        access(1'b1, 21'h100005, 4'b0011, 32'hAABBCCDD, 32'h0,
               lat, cc, wc, oc, bw);
        chk("ext_wr_lat", lat, 4);
        chk("ext_wr_we_cycles", wc, 1);
        chk("ext_wr_ce_cycles", cc, 3);
        chk("ext_wr_be_n", {60'd0, bw}, 64'hC);
        chk("ext_wr_base_quiet", oc, 0);
        access(1'b0, 21'h100005, 4'h0, 32'h0, 32'h1122CCDD,
               lat, cc, wc, oc, bw);
        chk("ext_rd_lat", lat, 2);

        access(1'b1, 21'h000007, 4'b0000, 32'h00000000, 32'h0,
               lat, cc, wc, oc, bw);
        chk("null_wr_lat", lat, 4);
        chk("null_wr_be_n", {60'd0, bw}, 64'hF);
        access(1'b0, 21'h000007, 4'h0, 32'h0, 32'hDEADBEEF,
               lat, cc, wc, oc, bw);

        // Mid-simulation reset with rdata holding a prior result.
        @(negedge clk_50M);
        #3 reset_n = 1'b0;
        #1 reset_checks("rst");
        @(negedge clk_50M);
        reset_n = 1'b1;

        // Reset during WR_PULSE; rewritten data equals the preload.
        @(negedge clk_50M);
        req = 1'b1; we = 1'b1; addr = 21'h3; be = 4'hF; wdata = 32'h55AA55AA;
        @(negedge clk_50M);
        req = 1'b0;
        chk("mw_busy_setup", {63'd0, busy}, 64'd1);
        @(negedge clk_50M);
        chk("mw_we_low", {63'd0, base_ram_we_n}, 64'd0);
        #3 reset_n = 1'b0;
        #1;
        chk("mw_strobes", {62'd0, base_ram_we_n, base_ram_ce_n}, 64'd3);
        chk("mw_drive", {62'd0, dut.drive_q}, 64'd0);
        chk("mw_busy", {63'd0, busy}, 64'd0);
        @(negedge clk_50M);
        reset_n = 1'b1;
        @(negedge clk_50M);
        chk("mw_idle_after", {62'd0, busy, ack}, 64'd0);
        access(1'b0, 21'h000003, 4'h0, 32'h0, 32'h55AA55AA,
               lat, cc, wc, oc, bw);
        chk("mw_rd_lat", lat, 2);

        // Held req: reads of words 0,1,0,1 accepted every third edge.
        for (int k = 0; k < 4; k++)
            sb_q.push_back('{rd: 1'b1,
                             data: (k % 2) ? 32'h01234567 : 32'h3C1F8040});
        @(negedge clk_50M);
        we = 1'b0; be = 4'h0;
        for (int k = 0; k < 14; k++) begin
            if (ack) acks.push_back(k);
            if (k == 3 || k == 6) chk($sformatf("held_idle_gap_%0d", k),
                                      {63'd0, busy}, 64'd0);
            if (k < 10) begin
                req  = 1'b1;
                addr = ((k / 3) % 2 == 1) ? 21'h1 : 21'h0;
            end else begin
                req = 1'b0;
            end
            @(negedge clk_50M);
        end
        chk("held_ack_count", acks.size(), 4);
        for (int i = 0; i < acks.size(); i++)
            chk($sformatf("held_ack_%0d", i), acks[i], 2 + 3 * i);

        repeat (3) @(negedge clk_50M);
        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
